// File: rtl/register_write_arbiter.sv
// Round-robin arbiter for the shared write port of a four-register bank, with a bounded owner lock.
// Ack is combinational in the request cycle, and the bank controls are registered one cycle later. Requesters without Ack simply wait.
module register_write_arbiter #(
  parameter int WIDTH    = 16,
  parameter int LOCK_MAX = 4
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic [2:0]         ReqValid,
  input  logic [5:0]         ReqReg,
  input  logic [8:0]         ReqFunSel,
  input  logic [3*WIDTH-1:0] ReqData,
  input  logic [2:0]         ReqLock,
  output logic [2:0]         Ack,
  output logic [3:0]         RegE,
  output logic [2:0]         RegFunSel,
  output logic [WIDTH-1:0]   RegI,
  output logic               Locked
);

  localparam int CW = $clog2(LOCK_MAX + 1);

  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       lock_own_q, lock_own_d;
  logic             lock_active_q, lock_active_d;
  logic [CW-1:0]    lock_cnt_q, lock_cnt_d;
  logic [3:0]       reg_e_q, reg_e_d;
  logic [2:0]       reg_fs_q, reg_fs_d;
  logic [WIDTH-1:0] reg_i_q, reg_i_d;

  logic [2:0]       grant;
  logic             xfer;
  logic [1:0]       win_idx;
  logic [1:0]       win_next;
  logic [1:0]       sel_reg;
  logic [2:0]       sel_fs;
  logic [WIDTH-1:0] sel_data;
  logic             sel_lock;
  logic             lock_continue;

  function automatic logic [2:0] rr_pick(input logic [1:0] p, input logic [2:0] v);
    logic [2:0] g;
    g = 3'b000;
    case (p)
      2'd1: begin
        if (v[1])      g = 3'b010;
        else if (v[2]) g = 3'b100;
        else if (v[0]) g = 3'b001;
      end
      2'd2: begin
        if (v[2])      g = 3'b100;
        else if (v[0]) g = 3'b001;
        else if (v[1]) g = 3'b010;
      end
      default: begin
        if (v[0])      g = 3'b001;
        else if (v[1]) g = 3'b010;
        else if (v[2]) g = 3'b100;
      end
    endcase
    return g;
  endfunction

  // A held lock parks the port on its owner even while the owner is not requesting.
  always_comb begin
    grant = 3'b000;
    if (lock_active_q) begin
      case (lock_own_q)
        2'd1:    grant = {1'b0, ReqValid[1], 1'b0};
        2'd2:    grant = {ReqValid[2], 2'b00};
        default: grant = {2'b00, ReqValid[0]};
      endcase
    end else begin
      grant = rr_pick(ptr_q, ReqValid);
    end
  end

  assign Ack  = Reset ? 3'b000 : grant;
  assign xfer = |grant;

  always_comb begin
    win_idx = 2'd0;
    if (grant[2])      win_idx = 2'd2;
    else if (grant[1]) win_idx = 2'd1;
  end

  always_comb begin
    sel_reg  = ReqReg[1:0];
    sel_fs   = ReqFunSel[2:0];
    sel_data = ReqData[WIDTH-1:0];
    sel_lock = ReqLock[0];
    win_next = 2'd1;
    case (win_idx)
      2'd1: begin
        sel_reg  = ReqReg[3:2];
        sel_fs   = ReqFunSel[5:3];
        sel_data = ReqData[2*WIDTH-1:WIDTH];
        sel_lock = ReqLock[1];
        win_next = 2'd2;
      end
      2'd2: begin
        sel_reg  = ReqReg[5:4];
        sel_fs   = ReqFunSel[8:6];
        sel_data = ReqData[3*WIDTH-1:2*WIDTH];
        sel_lock = ReqLock[2];
        win_next = 2'd0;
      end
      default: ;
    endcase
  end

  // The grant that would reach LOCK_MAX consecutive grants always releases.
  assign lock_continue = sel_lock &&
                         (({1'b0, lock_cnt_q} + (CW+1)'(1)) < (CW+1)'(LOCK_MAX));

  always_comb begin
    ptr_d         = ptr_q;
    lock_own_d    = lock_own_q;
    lock_active_d = lock_active_q;
    lock_cnt_d    = lock_cnt_q;
    reg_e_d       = 4'b0000;
    reg_fs_d      = reg_fs_q;
    reg_i_d       = reg_i_q;
    if (xfer) begin
      reg_e_d  = 4'b0001 << sel_reg;
      reg_fs_d = sel_fs;
      reg_i_d  = sel_data;
      if (lock_continue) begin
        lock_active_d = 1'b1;
        lock_own_d    = win_idx;
        lock_cnt_d    = lock_cnt_q + CW'(1);
      end else begin
        lock_active_d = 1'b0;
        lock_cnt_d    = '0;
        ptr_d         = win_next;
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      ptr_q         <= 2'd0;
      lock_own_q    <= 2'd0;
      lock_active_q <= 1'b0;
      lock_cnt_q    <= '0;
      reg_e_q       <= 4'b0000;
      reg_fs_q      <= 3'b000;
      reg_i_q       <= '0;
    end else begin
      ptr_q         <= ptr_d;
      lock_own_q    <= lock_own_d;
      lock_active_q <= lock_active_d;
      lock_cnt_q    <= lock_cnt_d;
      reg_e_q       <= reg_e_d;
      reg_fs_q      <= reg_fs_d;
      reg_i_q       <= reg_i_d;
    end
  end

  assign RegE      = reg_e_q;
  assign RegFunSel = reg_fs_q;
  assign RegI      = reg_i_q;
  assign Locked    = lock_active_q;

endmodule

// File: tb/tb_register_write_arbiter.sv
// Scoreboard bench for register_write_arbiter: expected bank writes are queued at request time and checked after the edge.
module tb_register_write_arbiter;

  localparam int WIDTH = 16;

  logic               Clock;
  logic               Reset;
  logic [2:0]         ReqValid;
  logic [5:0]         ReqReg;
  logic [8:0]         ReqFunSel;
  logic [3*WIDTH-1:0] ReqData;
  logic [2:0]         ReqLock;
  logic [2:0]         Ack;
  logic [3:0]         RegE;
  logic [2:0]         RegFunSel;
  logic [WIDTH-1:0]   RegI;
  logic               Locked;

  logic [1:0]       r  [3];
  logic [2:0]       fs [3];
  logic [WIDTH-1:0] d  [3];

  assign ReqReg    = {r[2], r[1], r[0]};
  assign ReqFunSel = {fs[2], fs[1], fs[0]};
  assign ReqData   = {d[2], d[1], d[0]};

  typedef struct {
    logic [3:0]       e;
    logic [2:0]       f;
    logic [WIDTH-1:0] i;
  } exp_t;

  exp_t             sb[$];
  logic [2:0]       last_fs;
  logic [WIDTH-1:0] last_i;
  int               pass_cnt;
  int               total_cnt;

  register_write_arbiter #(.WIDTH(WIDTH), .LOCK_MAX(4)) dut (
    .Clock(Clock), .Reset(Reset), .ReqValid(ReqValid), .ReqReg(ReqReg),
    .ReqFunSel(ReqFunSel), .ReqData(ReqData), .ReqLock(ReqLock), .Ack(Ack),
    .RegE(RegE), .RegFunSel(RegFunSel), .RegI(RegI), .Locked(Locked)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // One request cycle: check Ack now, queue the expected bank write, check outputs after the edge.
  task automatic step(input logic [2:0] exp_ack, input logic exp_locked, input string nm);
    exp_t e;
    int   w;
    exp_t got;
    #1;
    total_cnt++;
    if (Ack !== exp_ack) $display("FAIL %s ack: got %b want %b", nm, Ack, exp_ack);
    else pass_cnt++;
    if (exp_ack != 3'b000) begin
      w   = exp_ack[2] ? 2 : (exp_ack[1] ? 1 : 0);
      e.e = 4'b0001 << r[w];
      e.f = fs[w];
      e.i = d[w];
      last_fs = fs[w];
      last_i  = d[w];
    end else begin
      e.e = 4'b0000;
      e.f = last_fs;
      e.i = last_i;
    end
    sb.push_back(e);
    @(posedge Clock);
    #1;
    got = sb.pop_front();
    total_cnt++;
    if (RegE !== got.e) $display("FAIL %s RegE: got %b want %b", nm, RegE, got.e);
    else pass_cnt++;
    total_cnt++;
    if (RegFunSel !== got.f) $display("FAIL %s RegFunSel: got %b want %b", nm, RegFunSel, got.f);
    else pass_cnt++;
    total_cnt++;
    if (RegI !== got.i) $display("FAIL %s RegI: got %h want %h", nm, RegI, got.i);
    else pass_cnt++;
    total_cnt++;
    if (Locked !== exp_locked) $display("FAIL %s Locked: got %b want %b", nm, Locked, exp_locked);
    else pass_cnt++;
  endtask

  task automatic do_reset();
    @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    Reset   = 1'b0;
    last_fs = 3'b000;
    last_i  = '0;
  endtask

  task automatic check_reset_outputs(input string nm);
    total_cnt++;
    if ({Ack, RegE, RegFunSel, RegI, Locked} !== {3'b000, 4'b0000, 3'b000, 16'h0000, 1'b0})
      $display("FAIL %s: got Ack=%b RegE=%b FunSel=%b I=%h Locked=%b want all zero",
               nm, Ack, RegE, RegFunSel, RegI, Locked);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    Reset    = 1'b1;
    ReqValid = 3'b111;
    ReqLock  = 3'b000;
    for (int i = 0; i < 3; i++) begin
      r[i] = 2'(i); fs[i] = 3'(i + 1); d[i] = 16'h1000 * 16'(i + 1);
    end
    repeat (2) @(negedge Clock);
    check_reset_outputs("reset_state");
    ReqValid = 3'b000;
    Reset    = 1'b0;
    last_fs  = 3'b000;
    last_i   = '0;
  endtask

  task automatic test_single();
    ReqValid = 3'b010;
    r[1] = 2'd2; fs[1] = 3'b010; d[1] = 16'hBEEF;
    step(3'b010, 1'b0, "single_grant");
    ReqValid = 3'b000;
    step(3'b000, 1'b0, "single_idle");
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      r[i] = 2'(i); fs[i] = 3'(i + 1); d[i] = 16'h1000 * 16'(i + 1);
    end
    ReqValid = 3'b111;
    for (int k = 0; k < 6; k++)
      step(3'b001 << (k % 3), 1'b0, $sformatf("rr_%0d", k));
  endtask

  task automatic test_lock_release();
    ReqValid = 3'b010;
    step(3'b010, 1'b0, "lockrel_setup");
    ReqValid = 3'b111;
    ReqLock  = 3'b100;
    r[2] = 2'd0; fs[2] = 3'b101; d[2] = 16'h0034;
    step(3'b100, 1'b1, "lockrel_low");
    ReqLock = 3'b000;
    fs[2] = 3'b110; d[2] = 16'h0012;
    step(3'b100, 1'b0, "lockrel_high");
    step(3'b001, 1'b0, "lockrel_next");
  endtask

  task automatic test_lock_max();
    do_reset();
    ReqValid = 3'b011;
    ReqLock  = 3'b001;
    for (int k = 0; k < 4; k++) begin
      d[0] = 16'hA000 + 16'(k);
      step(3'b001, (k < 3), $sformatf("lockmax_%0d", k));
    end
    step(3'b010, 1'b0, "lockmax_release");
  endtask

  task automatic test_owner_gap();
    ReqValid = 3'b011;
    ReqLock  = 3'b001;
    d[0] = 16'h5A5A;
    step(3'b001, 1'b1, "gap_lock");
    ReqValid = 3'b010;
    step(3'b000, 1'b1, "gap_idle0");
    step(3'b000, 1'b1, "gap_idle1");
    ReqValid = 3'b011;
    ReqLock  = 3'b000;
    d[0] = 16'h6B6B;
    step(3'b001, 1'b0, "gap_return");
    step(3'b010, 1'b0, "gap_other");
  endtask

  task automatic test_reset_mid_lock();
    ReqValid = 3'b011;
    ReqLock  = 3'b001;
    d[0] = 16'hC0DE;
    step(3'b001, 1'b1, "midrst_lock");
    #2;
    Reset = 1'b1;
    #1;
    check_reset_outputs("midrst_async");
    @(negedge Clock);
    Reset   = 1'b0;
    last_fs = 3'b000;
    last_i  = '0;
    ReqValid = 3'b111;
    ReqLock  = 3'b000;
    step(3'b001, 1'b0, "midrst_prio");
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_lock_release();
    test_lock_max();
    test_owner_gap();
    test_reset_mid_lock();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
